// File: rtl/circle_sequencer.sv
// -----------------------------------------------------------------------------
// circle_sequencer
//
// Generates the row/col position consumed by the 7-segment circle driver so
// that a single lit segment chases around the display bank as a closed loop:
// left-to-right along the top row, right-to-left along the bottom row
// (clockwise), or the exact reverse path (counter-clockwise).
//
// A prescaler produces one step every (TICK_DIV >> speed) clock cycles.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   run    - 1 = advance, 0 = freeze position and prescaler
//   dir    - 0 = clockwise, 1 = counter-clockwise (sampled only at a tick)
//   speed  - step period = TICK_DIV >> speed cycles
//   clear  - synchronous return to home (row 0, col 0); overrides a tick
//   row    - 0 = top row, 1 = bottom row
//   col    - active digit index, 0..DISPLAY_COUNT-1
//   step   - one-cycle pulse on the cycle row/col change
//   lap    - one-cycle pulse when a step lands on home (0,0)
// -----------------------------------------------------------------------------
module circle_sequencer #(
   parameter int DISPLAY_COUNT = 6,
   parameter int COL_WIDTH     = $clog2(DISPLAY_COUNT),
   parameter int TICK_DIV      = 25_000_000,
   parameter int DIV_WIDTH     = $clog2(TICK_DIV)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic                 dir,
   input  logic [1:0]           speed,
   input  logic                 clear,
   output logic                 row,
   output logic [COL_WIDTH-1:0] col,
   output logic                 step,
   output logic                 lap
);

   localparam logic [COL_WIDTH-1:0] COL_LAST   = COL_WIDTH'(DISPLAY_COUNT - 1);
   localparam logic [31:0]          TICK_DIV_U = 32'(TICK_DIV);

   typedef enum logic {
      TOP    = 1'b0,
      BOTTOM = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [COL_WIDTH-1:0] col_q,   col_d;
   logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
   logic                 step_q,  step_d;
   logic                 lap_q,   lap_d;

   logic [31:0]          limit_m1;
   logic                 tick;

   // The limit follows speed immediately; using >= rather than == means a
   // count already past a freshly shortened limit still fires on this cycle
   // instead of running off to the counter's natural wrap.
   assign limit_m1 = (TICK_DIV_U >> speed) - 32'd1;
   assign tick     = run && (32'(cnt_q) >= limit_m1);

   // NOTE: every signal written here gets a default first; without it any path
   // that skips an assignment would infer a latch.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      step_d  = 1'b0;
      lap_d   = 1'b0;

      if (clear) begin
         state_d = TOP;
         col_d   = '0;
         cnt_d   = '0;
      end else if (tick) begin
         cnt_d  = '0;
         step_d = 1'b1;
         case (state_q)
            TOP: begin
               if (!dir) begin
                  if (col_q == COL_LAST) state_d = BOTTOM;
                  else                   col_d   = col_q + COL_WIDTH'(1);
               end else begin
                  if (col_q == '0)       state_d = BOTTOM;
                  else                   col_d   = col_q - COL_WIDTH'(1);
               end
            end
            BOTTOM: begin
               if (!dir) begin
                  if (col_q == '0)       state_d = TOP;
                  else                   col_d   = col_q - COL_WIDTH'(1);
               end else begin
                  if (col_q == COL_LAST) state_d = TOP;
                  else                   col_d   = col_q + COL_WIDTH'(1);
               end
            end
         endcase
         // Home is only reachable by a step, so the lap pulse rides on it.
         lap_d = (state_d == TOP) && (col_d == '0);
      end else if (run) begin
         cnt_d = cnt_q + DIV_WIDTH'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TOP;
         col_q   <= '0;
         cnt_q   <= '0;
         step_q  <= 1'b0;
         lap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         lap_q   <= lap_d;
      end
   end

   assign row  = (state_q == BOTTOM);
   assign col  = col_q;
   assign step = step_q;
   assign lap  = lap_q;

endmodule

// File: tb/tb_circle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_circle_sequencer
//
// Self-checking bench for circle_sequencer (DISPLAY_COUNT=6, TICK_DIV=8).
// The reference model tracks the position as an index 0..2N-1 around the
// loop and a plain integer prescaler count; row/col are derived from the
// index arithmetically. Directed scenarios are followed by a random phase.
// -----------------------------------------------------------------------------
module tb_circle_sequencer;

   localparam int N  = 6;
   localparam int TD = 8;
   localparam int CW = $clog2(N);

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          run   = 1'b0;
   logic          dir   = 1'b0;
   logic [1:0]    speed = 2'd0;
   logic          clear = 1'b0;
   logic          row;
   logic [CW-1:0] col;
   logic          step;
   logic          lap;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_p;
   int m_cnt;
   int m_step;
   int m_lap;

   circle_sequencer #(
      .DISPLAY_COUNT(N),
      .TICK_DIV     (TD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .dir  (dir),
      .speed(speed),
      .clear(clear),
      .row  (row),
      .col  (col),
      .step (step),
      .lap  (lap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int pos_row(input int p);
      return (p >= N) ? 1 : 0;
   endfunction

   function automatic int pos_col(input int p);
      return (p < N) ? p : (2 * N - 1 - p);
   endfunction

   task automatic model_reset();
      m_p    = 0;
      m_cnt  = 0;
      m_step = 0;
      m_lap  = 0;
   endtask

   // One clock edge of the reference, using the inputs held across the edge.
   task automatic model_edge();
      if (clear) begin
         model_reset();
      end else if (run && (m_cnt >= (TD >> speed) - 1)) begin
         m_cnt  = 0;
         m_p    = dir ? (m_p + 2 * N - 1) % (2 * N) : (m_p + 1) % (2 * N);
         m_step = 1;
         m_lap  = (m_p == 0) ? 1 : 0;
      end else begin
         m_step = 0;
         m_lap  = 0;
         if (run) m_cnt++;
      end
   endtask

   task automatic compare_outputs(input string tag);
      check({tag, ".row"},  int'(row),  pos_row(m_p));
      check({tag, ".col"},  int'(col),  pos_col(m_p));
      check({tag, ".step"}, int'(step), m_step);
      check({tag, ".lap"},  int'(lap),  m_lap);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_outputs(tag);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cycle("clr");
      clear = 1'b0;
   endtask

   initial begin
      int steps, laps, lap_at, first_i, gap, k;

      // Reset state
      model_reset();
      #12;
      check("reset.row",  int'(row),  0);
      check("reset.col",  int'(col),  0);
      check("reset.step", int'(step), 0);
      check("reset.lap",  int'(lap),  0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: clockwise, one full lap
      run = 1'b1; dir = 1'b0; speed = 2'd0;
      steps = 0; laps = 0; lap_at = -1; first_i = -1;
      for (int i = 0; i < 12 * TD; i++) begin
         cycle("t1");
         if (step) begin
            steps++;
            if (first_i < 0) first_i = i;
            if (lap) lap_at = steps;
         end
         if (lap) laps++;
      end
      check("t1.steps",      steps,   12);
      check("t1.laps",       laps,    1);
      check("t1.lap_at",     lap_at,  12);
      check("t1.first_step", first_i, TD - 1);

      // 2: counter-clockwise, one full lap, positions against a fixed table
      dir = 1'b1;
      steps = 0; lap_at = -1;
      for (int i = 0; i < 12 * TD; i++) begin
         cycle("t2");
         if (step) begin
            steps++;
            k = steps;
            if (k <= N) check("t2.seq", int'(row) * 8 + int'(col), 8 + (k - 1));
            else        check("t2.seq", int'(row) * 8 + int'(col), 2 * N - k);
            if (lap) lap_at = steps;
         end
      end
      check("t2.steps",  steps,  12);
      check("t2.lap_at", lap_at, 12);

      // 3: speed=3 steps every cycle; back to speed=0 from prescaler 0
      speed = 2'd3;
      for (int i = 0; i < 5; i++) begin
         cycle("t3");
         check("t3.fast_step", int'(step), 1);
      end
      speed = 2'd0;
      gap = -1;
      for (int i = 1; i <= 20; i++) begin
         cycle("t3");
         if (step) begin gap = i; break; end
      end
      check("t3.gap", gap, TD);

      // 4: freeze at (0,3) with prescaler at 5, then resume
      dir = 1'b0;
      do_clear();
      for (int i = 0; i < 3 * TD + 5; i++) cycle("t4");
      check("t4.pre_row", int'(row), 0);
      check("t4.pre_col", int'(col), 3);
      run = 1'b0;
      steps = 0;
      for (int i = 0; i < 20; i++) begin
         cycle("t4.hold");
         if (step) steps++;
      end
      check("t4.hold_steps", steps, 0);
      check("t4.hold_col",   int'(col), 3);
      run = 1'b1;
      gap = -1;
      for (int i = 1; i <= 20; i++) begin
         cycle("t4");
         if (step) begin gap = i; break; end
      end
      check("t4.resume_gap", gap, 3);
      check("t4.resume_col", int'(col), 4);
      check("t4.resume_row", int'(row), 0);

      // 5: reverse at (1,2) while clockwise; then clear on a tick
      do_clear();
      for (int i = 0; i < 9 * TD; i++) cycle("t5");
      check("t5.pre", int'(row) * 8 + int'(col), 8 + 2);
      dir = 1'b1;
      steps = 0;
      for (int i = 0; i < 5 * TD && steps < 4; i++) begin
         cycle("t5");
         if (step) begin
            steps++;
            case (steps)
               1: check("t5.rev1", int'(row) * 8 + int'(col), 8 + 3);
               2: check("t5.rev2", int'(row) * 8 + int'(col), 8 + 4);
               3: check("t5.rev3", int'(row) * 8 + int'(col), 8 + 5);
               default: check("t5.rev4", int'(row) * 8 + int'(col), 5);
            endcase
         end
      end
      check("t5.rev_steps", steps, 4);
      for (int i = 0; i < TD - 1; i++) cycle("t5");
      clear = 1'b1;
      cycle("t5.clr");
      clear = 1'b0;
      check("t5.clr_step", int'(step), 0);
      check("t5.clr_lap",  int'(lap),  0);
      check("t5.clr_pos",  int'(row) * 8 + int'(col), 0);

      // 6: async reset between edges at (1,4)
      dir = 1'b0;
      do_clear();
      for (int i = 0; i < 7 * TD; i++) cycle("t6");
      check("t6.pre",      int'(row) * 8 + int'(col), 8 + 4);
      check("t6.pre_step", int'(step), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t6.rst_row",  int'(row),  0);
      check("t6.rst_col",  int'(col),  0);
      check("t6.rst_step", int'(step), 0);
      check("t6.rst_lap",  int'(lap),  0);
      model_reset();
      #1 rst_n = 1'b1;
      gap = -1;
      for (int i = 1; i <= 20; i++) begin
         cycle("t6");
         if (step) begin gap = i; break; end
      end
      check("t6.first_gap", gap, TD);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) dir = ~dir;
         if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
         clear = ($urandom_range(0, 99) == 0);
         cycle("rnd");
      end
      clear = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
